// File: rtl/cas_lock_seq.sv
// cas_lock_seq: serially keyed, two-stage pipelined cascaded-AND/OR output-corruption unit.
// Optional macro CAS_LOCK_FLIP_CNT_EN adds a saturating 16-bit flip_count output.
module cas_lock_seq #(
    parameter int              N_IN          = 32,
    parameter logic [N_IN-1:0] CHAIN_PATTERN = N_IN'(32'h3E40_7DA0)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic            key_bit,
    output logic            key_ready,
    output logic            key_done,
    input  logic            key_clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    input  logic            func_in,
    output logic            out_valid,
    output logic            out_data
`ifdef CAS_LOCK_FLIP_CNT_EN
    ,
    output logic [15:0]     flip_count
`endif
);

    localparam int KEY_W = 2 * N_IN;
    localparam int IDX_W = $clog2(KEY_W);

    typedef enum logic {
        LOAD,
        ARMED
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   key;
    logic [IDX_W-1:0]   idx;

    logic [N_IN-1:0]    xa;
    logic [N_IN-1:0]    xb;
    logic               func_s1;
    logic               valid_s1;

    logic               c_a;
    logic               c_b;
    logic               flip;

    // Bit 1 of the pattern is never consulted: the first merge is always AND.
    function automatic logic cascade(input logic [N_IN-1:0] x);
        logic c;
        c = x[0] & x[1];
        for (int i = 2; i < N_IN; i++) begin
            c = CHAIN_PATTERN[i] ? (x[i] | c) : (x[i] & c);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            state     <= LOAD;
            key       <= '0;
            idx       <= '0;
            key_ready <= 1'b1;
            key_done  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (key_valid) begin
                        key[idx] <= key_bit;
                        if (idx == IDX_W'(KEY_W - 1)) begin
                            idx       <= '0;
                            state     <= ARMED;
                            key_ready <= 1'b0;
                            key_done  <= 1'b1;
                            in_ready  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    key_ready <= 1'b0;
                    key_done  <= 1'b1;
                    in_ready  <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_comb begin
        c_a  = cascade(xa);
        c_b  = cascade(xb);
        flip = c_a & ~c_b;
    end

    // A clear kills both pipeline valids so nothing keyed with the old key escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            xa        <= '0;
            xb        <= '0;
            func_s1   <= 1'b0;
            valid_s1  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
        end else if (key_clear) begin
            valid_s1  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            valid_s1 <= in_valid & in_ready;
            if (in_valid && in_ready) begin
                xa      <= in_data ^ key[N_IN-1:0];
                xb      <= in_data ^ key[KEY_W-1:N_IN];
                func_s1 <= func_in;
            end
            out_valid <= valid_s1;
            out_data  <= func_s1 ^ flip;
        end
    end

`ifdef CAS_LOCK_FLIP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            flip_count <= '0;
        end else if (valid_s1 && flip && flip_count != 16'hFFFF) begin
            flip_count <= flip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cas_lock_seq.sv
// Scoreboard bench for cas_lock_seq with N_IN=4, CHAIN_PATTERN=4'b0100.
// Expected results are pushed at issue time and popped by an independent output monitor.
module tb_cas_lock_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic       key_bit;
    logic       key_ready;
    logic       key_done;
    logic       key_clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       func_in;
    logic       out_valid;
    logic       out_data;
`ifdef CAS_LOCK_FLIP_CNT_EN
    logic [15:0] flip_count;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_q[$];

    cas_lock_seq #(
        .N_IN          (4),
        .CHAIN_PATTERN (4'b0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .key_done   (key_done),
        .key_clear  (key_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .func_in    (func_in),
        .out_valid  (out_valid),
        .out_data   (out_data)
`ifdef CAS_LOCK_FLIP_CNT_EN
        ,
        .flip_count (flip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Output monitor: every out_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] data, input logic func,
                                 input bit push, input logic expected);
        in_valid = 1'b1;
        in_data  = data;
        func_in  = func;
        if (push) exp_q.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
    endtask

    task automatic loadKey(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            if (i == 7) checkOutput("key_done_before_last_beat", 32'(key_done), 32'd0);
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        @(negedge clk);
        checkOutput("key_done_after_load", 32'(key_done), 32'd1);
        checkOutput("key_ready_after_load", 32'(key_ready), 32'd0);
        checkOutput("in_ready_after_load", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_outstanding", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic f;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_bit   = 1'b0;
        key_clear = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        func_in   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_key_ready", 32'(key_ready), 32'd1);
        checkOutput("reset_key_done", 32'(key_done), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;

        // Key 8'h10: chain A key 0000, chain B key 0001.
        loadKey(8'h10);

        key_valid = 1'b1;
        key_bit   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        checkOutput("key_done_after_extra_beats", 32'(key_done), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(4'b1011, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'b0011, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

        // All-zero key: both chains see the same value, so nothing ever flips.
        pulseClear();
        loadKey(8'h00);
        for (int d = 0; d < 16; d++) begin
            f = 1'($urandom_range(0, 1));
            applyStimulus(4'(d), f, 1'b1, f);
        end
        in_valid = 1'b0;
        drain();

        pulseClear();
        loadKey(8'h10);
        applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 4'b1011;
        key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clear_key_ready", 32'(key_ready), 32'd1);
        checkOutput("clear_in_ready", 32'(in_ready), 32'd0);
        checkOutput("clear_key_done", 32'(key_done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("load_ignores_data", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

`ifdef CAS_LOCK_FLIP_CNT_EN
        loadKey(8'h10);
        for (int n = 0; n < 70000; n++) applyStimulus(4'b1011, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();
        checkOutput("flip_count_saturated", 32'(flip_count), 32'h0000FFFF);
        pulseClear();
        @(negedge clk);
        checkOutput("flip_count_cleared", 32'(flip_count), 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
